// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and operand-signedness decode helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input op_e o);
        return o inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_signed_a(input op_e o);
        return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input op_e o);
        return o inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add for multiply (hi:lo is the
// partial product, lo holds the remaining multiplier bits) or restoring
// shift-subtract for divide (hi is the partial remainder, lo the quotient).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] m_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
        shifted = {hi_i, lo_i[XLEN-1]};
        diff    = shifted - {1'b0, m_i};
        if (is_div_i) begin
            // Partial remainder stays below 2*divisor, so bit XLEN of diff is a true sign.
            if (!diff[XLEN]) begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shifted[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV-style multiply/divide unit with valid/ready handshakes.
// Build option MULDIV_EARLY_OUT_EN: zero divisor or zero multiplicand finishes at once.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d;

    op_e             op_in;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] q_fix, r_fix, final_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_is_div(op_q)),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        op_in = op_e'(op);
        a_neg = op_signed_a(op_in) & opa[XLEN-1];
        b_neg = op_signed_b(op_in) & opb[XLEN-1];
        a_mag = a_neg ? -opa : opa;
        b_mag = b_neg ? -opb : opb;
    end

    // neg_q holds the sign to apply to whichever half the op selects.
    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        q_fix    = neg_q ? -lo_q : lo_q;
        r_fix    = neg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = q_fix;
            default:                      final_res = r_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op_in;
                    count_d = '0;
                    hi_d    = '0;
                    state_d = CALC;
                    if (op_is_div(op_in)) begin
                        lo_d = a_mag;
                        m_d  = b_mag;
                        // A zero divisor must yield an all-ones quotient regardless of signs.
                        neg_d = op_is_rem(op_in) ? a_neg : ((a_neg ^ b_neg) & (opb != '0));
                    end else begin
                        lo_d  = b_mag;
                        m_d   = a_mag;
                        neg_d = a_neg ^ b_neg;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    if (opb == '0 || (!op_is_div(op_in) && opa == '0)) begin
                        state_d  = DONE;
                        result_d = !op_is_div(op_in) ? '0 : (op_is_rem(op_in) ? opa : '1);
                    end
`endif
                end
            end
            CALC: begin
                if (count_q == LAST) begin
                    result_d = final_res;
                    state_d  = DONE;
                end else begin
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    result_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = (state_q == DONE) ? result_q : '0;

endmodule
